// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_CALL,
    SEL_RET,
    SEL_IRQ,
    SEL_HOLD
  } pc_sel_t;

  localparam int unsigned STEP_SHORT = 1;
  localparam int unsigned STEP_LONG  = 2;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack as a circular buffer: a full push overwrites the oldest entry.
module ret_addr_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              wdata,
  output logic [ADDR_W-1:0]              top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic                           ovf,
  output logic                           unf
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic              full;
  logic              empty;

  assign full  = (count == CNT_W'(RAS_DEPTH));
  assign empty = (count == '0);

  // Explicit wrap so non-power-of-two depths stay circular.
  assign ptr_inc = (top_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_ptr + PTR_W'(1);
  assign ptr_dec = (top_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : top_ptr - PTR_W'(1);

  assign top = mem[top_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else if (push) begin
      top_ptr <= ptr_inc;
      if (full) begin
        ovf <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        top_ptr <= ptr_dec;
        count   <= count - CNT_W'(1);
      end
    end
  end

  // Entry contents need no reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[ptr_inc] <= wdata;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Priority-resolved next-PC unit: irq > ret > call > branch > sequential, with an internal RAS.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = 32'h20,
  parameter logic [ADDR_W-1:0]  IRQ_VEC   = 32'h0,
  parameter int unsigned        RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pc_en,
  input  logic                           inst_len,
  input  logic                           branch_take,
  input  logic [ADDR_W-1:0]              branch_addr,
  input  logic                           call,
  input  logic [ADDR_W-1:0]              call_addr,
  input  logic [ADDR_W-1:0]              link_addr,
  input  logic                           ret,
  input  logic                           irq,
  output logic [ADDR_W-1:0]              pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  pc_sel_t           sel;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] ras_wdata;
  logic              ras_push;
  logic              ras_pop;

  always_comb begin
    sel = SEL_SEQ;
    if (!pc_en) begin
      sel = SEL_HOLD;
    end else if (irq) begin
      sel = SEL_IRQ;
    end else if (ret) begin
      sel = SEL_RET;
    end else if (call) begin
      sel = SEL_CALL;
    end else if (branch_take) begin
      sel = SEL_BR;
    end
  end

  assign ras_push  = (sel == SEL_IRQ) || (sel == SEL_CALL);
  assign ras_pop   = (sel == SEL_RET);
  // Interrupts save the un-fetched pc so a later ret resumes there.
  assign ras_wdata = (sel == SEL_IRQ) ? pc : link_addr;

  always_comb begin
    pc_next = pc;
    unique case (sel)
      SEL_SEQ:  pc_next = pc + (inst_len ? ADDR_W'(STEP_LONG) : ADDR_W'(STEP_SHORT));
      SEL_BR:   pc_next = branch_addr;
      SEL_CALL: pc_next = call_addr;
      SEL_RET:  pc_next = (ras_count == '0) ? RESET_VEC : ras_top;
      SEL_IRQ:  pc_next = IRQ_VEC;
      SEL_HOLD: pc_next = pc;
      default:  pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VEC;
    end else begin
      pc <= pc_next;
    end
  end

  ret_addr_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .wdata (ras_wdata),
    .top   (ras_top),
    .count (ras_count),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage. It replaces the fixed four-way PC select with a priority-resolved next-PC unit. The unit handles variable instruction length, branches, calls and returns through an internal return-address stack (RAS), and interrupt entry. It sits in front of instruction memory, and its registered `pc` drives the fetch address directly.

## Interface
- `ADDR_W`, 32: PC / address width.
- `RESET_VEC`, 32'h20: PC value after reset; also the fallback target on RAS underflow.
- `IRQ_VEC`, 32'h0: interrupt entry address.
- `RAS_DEPTH`, 4: number of RAS entries; must be ≥ 2.

Ports:
- `clk`  in  1  sole clock; everything updates on its rising edge.
- `rst`  in  1  reset is synchronous and active-high.
- `pc_en`  in  1  1 = advance; 0 = stall, with PC, RAS and flags all held.
- `inst_len`  in  1  length of the instruction at `pc`: 0 = one word (+1), 1 = two words (+2).
- `branch_take`  in  1  redirect to `branch_addr`.
- `branch_addr`  in  ADDR_W  branch target.
- `call`  in  1  jump to `call_addr` and push `link_addr`.
- `call_addr`  in  ADDR_W  call target.
- `link_addr`  in  ADDR_W  return address supplied by the decode/execute stage.
- `ret`  in  1  pop the RAS and jump to the popped value.
- `irq`  in  1  jump to `IRQ_VEC` and push the current `pc`.
- `pc`  out  ADDR_W  registered fetch address.
- `ras_count`  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- `ras_ovf`  out  1  sticky: a push was made while the RAS was full.
- `ras_unf`  out  1  sticky: a pop was made while the RAS was empty.

## Operation
- The select priority is evaluated every cycle in this order: `rst` > `!pc_en` > `irq` > `ret` > `call` > `branch_take` > sequential.
- **Reset:** `pc`=RESET_VEC, `ras_count`=0, `ras_ovf`=0, `ras_unf`=0. RAS contents are don't-care.
- **Stall** (`pc_en`=0): all requests are ignored and dropped, not queued. The requester must hold them until `pc_en`=1.
- **Sequential:** `pc` ← `pc` + (`inst_len` ? 2 : 1), computed modulo 2^ADDR_W (all-ones + 1 → 0).
- **Branch:** `pc` ← `branch_addr`. The RAS is untouched.
- **Call:** push `link_addr`, then `pc` ← `call_addr`.
- **Ret:**
  - If not empty: `pc` ← top entry, then pop.
  - If empty: `pc` ← RESET_VEC, set `ras_unf`, and `ras_count` stays 0.
- **Irq:** push the current `pc` (the un-fetched address to resume at), then `pc` ← IRQ_VEC. A later `ret` resumes at the pushed address.
- **Push when full:** the oldest entry is overwritten (circular buffer), `ras_count` stays RAS_DEPTH, and `ras_ovf` is set.
- **Simultaneous requests:** only the highest-priority request acts. Lower-priority requests in the same cycle are discarded with no side effect, so `call`+`ret` results in a pop only.
- **Sticky flags:** `ras_ovf` and `ras_unf` clear only on `rst`.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- A request sampled at edge N is visible on `pc` and `ras_count` after edge N.
- The RAS top is read from registered state, so back-to-back `ret` in consecutive cycles pops consecutive entries.
- Reset mid-operation (e.g. during a `call`) wins outright: the next `pc` is RESET_VEC and the push does not occur.
- Throughput is one redirect per cycle, and there are no internal bubbles.

## Structure
- **Shared package `pc_seq_pkg`:**
  - `pc_sel_t` enum: SEL_SEQ, SEL_BR, SEL_CALL, SEL_RET, SEL_IRQ, SEL_HOLD.
  - Step constants `STEP_SHORT`=1 and `STEP_LONG`=2.
- **Sub-module `ret_addr_stack`** (parameters ADDR_W, RAS_DEPTH):
  - Inputs: push, pop, wdata.
  - Outputs: top, count, ovf, unf.
  - Implemented as a circular top pointer.
- The top level contains the priority encoder, the next-PC mux and the PC register.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `pc_en`=1 → `pc`=0x20, `ras_count`=0, both flags 0. Then 3 sequential cycles with `inst_len`=0,1,0 → `pc` = 0x21, 0x23, 0x24.
- **Call/return:** from `pc`=0x40, assert `call` with `call_addr`=0x100 and `link_addr`=0x42 → `pc`=0x100, `ras_count`=1. Then assert `ret` → `pc`=0x42, `ras_count`=0.
- **Overflow and underflow (RAS_DEPTH=4):** 5 calls with links 0xA1..0xA5 → `ras_ovf`=1 and `ras_count`=4. Then 4 rets → `pc` = 0xA5, 0xA4, 0xA3, 0xA2. A 5th ret → `pc`=0x20 and `ras_unf`=1.
- **Priority:** at `pc`=0x50, assert `irq`, `ret`, `call` and `branch_take` together → `pc`=IRQ_VEC(0) and top entry 0x50. Next cycle assert `call`+`ret` → `pc`=0x50 with no push.
- **Stall:** `pc_en`=0 with `call` asserted for 3 cycles → `pc` and `ras_count` unchanged. Also drive `pc`=32'hFFFF_FFFF with `inst_len`=1 → wraps to 0x1.
- **Reset mid-call:** assert `rst` together with `call` → `pc`=0x20, `ras_count`=0, flags cleared.
